scanline_crossing_counter: RTL and testbench
============================================

SCANLINE_CROSSING_COUNTER -- requirements
Module: scanline_crossing_counter

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame.
REQ-003 SHALL have parameter N_V, default 2, number of vertical scan lines.
REQ-004 SHALL have parameter N_H, default 3, number of horizontal scan lines.
REQ-005 SHALL have parameter MIN_GAP, default 3, minimum zero-run (1..15) preceding a counted crossing.
REQ-006 SHALL have parameter CW, default 4, per-line count width.
REQ-007 SHALL have ports clk in 1 (sole clock) and reset in 1 (synchronous, active-high).
REQ-008 SHALL have ports vsync in 1 (high = frame active), clken in 1 (pixel valid), bin in 1 (foreground = 1).
REQ-009 SHALL have ports line_top, line_bottom, line_left, line_right, each in 11, the figure bounding box.
REQ-010 SHALL have ports v_frac in N_V*4 and h_frac in N_H*4, per-line position numerators over 16.
REQ-011 SHALL have ports v_cnt out N_V*CW and h_cnt out N_H*CW, latched crossing counts.
REQ-012 SHALL have port h_side out N_H: per horizontal line, 1 = last counted crossing lies left of vertical line 0.
REQ-013 SHALL have ports v_sat out N_V and h_sat out N_H, count-saturated flags.
REQ-014 SHALL have port cnt_valid out 1, one-cycle pulse when outputs update.

Function
REQ-015 x/y counters SHALL clear while vsync=0; on clken, x increments, wrapping at IMG_W-1 to 0 with y+1.
REQ-016 On the vsync rising edge the bounding box, v_frac and h_frac SHALL be captured; mid-frame input changes have no effect.
REQ-017 Vertical line k position SHALL be left + ((right-left)*v_frac[k])>>4; horizontal line k SHALL be top + ((bottom-top)*h_frac[k])>>4; shift only, no dividers.
REQ-018 A vertical line SHALL sample bin only when clken, x == position and top < y < bottom; a horizontal line only when clken, y == position and left < x < right.
REQ-019 Each line SHALL hold a zero-run counter saturating at MIN_GAP, preset to MIN_GAP at frame start.
REQ-020 Sample bin=1 with run == MIN_GAP SHALL increment the count and clear the run; bin=1 otherwise clears the run only; bin=0 increments the run.
REQ-021 Counts SHALL saturate at 2^CW-1; an increment attempted at saturation SHALL set that line's sat flag.
REQ-022 Each horizontal-line crossing SHALL record x < vertical line 0 position; the value from the last crossing is kept.
REQ-023 If right <= left or bottom <= top (captured values), no sample SHALL be taken that frame.
REQ-024 Per-line counts, runs and sides SHALL clear on the vsync rising edge.
REQ-025 On the vsync falling edge (registered vsync 1, current 0), outputs SHALL load from the per-line state on the next clock edge, with cnt_valid high for exactly that cycle.
REQ-026 Outputs SHALL hold between updates; a frame truncated by reset SHALL never be published.

Reset
REQ-027 reset SHALL clear all outputs, counts, flags, x/y counters, the vsync register and captured geometry to 0; cnt_valid = 0.
REQ-028 reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 Package scanline_pkg SHALL hold COORD_W = 11, FRAC_W = 4 and the IMG_W/IMG_H defaults.
REQ-030 One sub-module crossing_detector (run counter, saturating count, sat flag) SHALL be instantiated N_V+N_H times via generate.

Verification
REQ-031 Blank frame -> all counts 0, all sat flags 0, a single cnt_valid pulse the cycle after vsync falls.
REQ-032 Box left=100 right=260 top=50 bottom=250, v_frac[0]=8 (x=180); rows 80-84 and 200-204 all 1 -> v_cnt[0]=2.
REQ-033 MIN_GAP=3, along one horizontal line: 1,0,0,1 -> count 1; 1,0,0,0,1 -> count 2.
REQ-034 CW=4, 20 separated crossings on one line -> count 15, sat flag 1.
REQ-035 h_frac[0]=8 with the last crossing at x=120 and vertical line 0 at x=180 -> h_side[0]=1; reset mid-frame -> all outputs 0 and no cnt_valid until the next full frame.
REQ-036 Box inputs changed mid-frame -> counts match the box captured at frame start.

Source files
------------

// File: rtl/scanline_pkg.sv
// scanline_pkg: shared widths, parameter defaults and the scan-line position helper
package scanline_pkg;
  localparam int COORD_W = 11;
  localparam int FRAC_W = 4;
  localparam int RUN_W = 4;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  // lo + ((hi - lo) * f) >> FRAC_W, shift only
  function automatic logic [COORD_W-1:0] line_pos(input logic [COORD_W-1:0] lo,
                                                   input logic [COORD_W-1:0] hi,
                                                   input logic [FRAC_W-1:0] f);
    logic [COORD_W+FRAC_W-1:0] p;
    p = (COORD_W+FRAC_W)'(hi - lo) * (COORD_W+FRAC_W)'(f);
    return lo + p[COORD_W+FRAC_W-1:FRAC_W];
  endfunction
endpackage

// File: rtl/crossing_detector.sv
// crossing_detector: per-line zero-run gated crossing counter with saturation flag
//   clr_i  frame-start clear (run preset to MIN_GAP), smp_i/bin_i sample strobe and pixel
//   hit_o  counted crossing this cycle, cnt_o saturating count, sat_o increment-at-max seen
module crossing_detector
  import scanline_pkg::*;
#(
  parameter int MIN_GAP = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          smp_i,
  input  logic          bin_i,
  output logic          hit_o,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);
  localparam logic [RUN_W-1:0] GAP = RUN_W'(MIN_GAP);
  logic [RUN_W-1:0] run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d;
  assign hit_o = smp_i & bin_i & (run_q == GAP);
  assign cnt_o = cnt_q;
  assign sat_o = sat_q;
  always_comb begin
    run_d = !smp_i ? run_q : bin_i ? '0 : run_q == GAP ? GAP : run_q + RUN_W'(1);
    cnt_d = (hit_o & !(&cnt_q)) ? cnt_q + CW'(1) : cnt_q;
    sat_d = sat_q | (hit_o & (&cnt_q));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      run_q <= GAP;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: rtl/scanline_crossing_counter.sv
// scanline_crossing_counter: counts figure crossings along fractional scan lines per frame
//   vsync/clken/bin  frame gate, pixel strobe, binary pixel
//   line_*, *_frac   bounding box and line fractions, captured on vsync rise
//   v_cnt/h_cnt, v_sat/h_sat, h_side, cnt_valid  per-frame results, published after vsync fall
module scanline_crossing_counter
  import scanline_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int N_V = 2,
  parameter int N_H = 3,
  parameter int MIN_GAP = 3,
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  clken,
  input  logic                  bin,
  input  logic [COORD_W-1:0]    line_top,
  input  logic [COORD_W-1:0]    line_bottom,
  input  logic [COORD_W-1:0]    line_left,
  input  logic [COORD_W-1:0]    line_right,
  input  logic [N_V*FRAC_W-1:0] v_frac,
  input  logic [N_H*FRAC_W-1:0] h_frac,
  output logic [N_V*CW-1:0]     v_cnt,
  output logic [N_H*CW-1:0]     h_cnt,
  output logic [N_H-1:0]        h_side,
  output logic [N_V-1:0]        v_sat,
  output logic [N_H-1:0]        h_sat,
  output logic                  cnt_valid
);
  localparam int N_L = N_V + N_H;
  logic vsync_q, ok_q, live_q;
  logic [COORD_W-1:0] x_q, y_q, top_q, bottom_q, left_q, right_q;
  logic [N_V*FRAC_W-1:0] v_frac_q;
  logic [N_H*FRAC_W-1:0] h_frac_q;
  logic [N_H-1:0] side_q;
  logic [COORD_W-1:0] pos [N_L];
  logic [N_L-1:0] smp, hit, sat_all;
  logic [N_L*CW-1:0] cnt_all;
  logic [N_V-1:0] unused_hit;
  logic rise, fall, act, x_end, y_end;
  // ok_q: vsync seen low since reset, so a reset landing mid-frame cannot fake a rising edge
  assign rise = vsync & ~vsync_q & ok_q;
  // live_q: a frame that started cleanly and has not been cut by reset
  assign fall = ~vsync & vsync_q & live_q;
  assign act = clken & vsync & live_q & (right_q > left_q) & (bottom_q > top_q);
  assign x_end = x_q == COORD_W'(IMG_W - 1);
  assign y_end = y_q == COORD_W'(IMG_H - 1);
  assign unused_hit = hit[N_V-1:0];
  for (genvar v = 0; v < N_V; v++) begin : g_v
    assign pos[v] = line_pos(left_q, right_q, v_frac_q[v*FRAC_W +: FRAC_W]);
    assign smp[v] = act & (x_q == pos[v]) & (y_q > top_q) & (y_q < bottom_q);
  end
  for (genvar h = 0; h < N_H; h++) begin : g_h
    assign pos[N_V+h] = line_pos(top_q, bottom_q, h_frac_q[h*FRAC_W +: FRAC_W]);
    assign smp[N_V+h] = act & (y_q == pos[N_V+h]) & (x_q > left_q) & (x_q < right_q);
  end
  for (genvar i = 0; i < N_L; i++) begin : g_det
    crossing_detector #(.MIN_GAP(MIN_GAP), .CW(CW)) u_det (
      .clk   (clk),
      .reset (reset),
      .clr_i (rise),
      .smp_i (smp[i]),
      .bin_i (bin),
      .hit_o (hit[i]),
      .cnt_o (cnt_all[i*CW +: CW]),
      .sat_o (sat_all[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      ok_q <= 1'b0;
      live_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      top_q <= '0;
      bottom_q <= '0;
      left_q <= '0;
      right_q <= '0;
      v_frac_q <= '0;
      h_frac_q <= '0;
      side_q <= '0;
    end else begin
      vsync_q <= vsync;
      ok_q <= ok_q | ~vsync;
      live_q <= rise | (live_q & vsync);
      x_q <= !vsync ? '0 : !clken ? x_q : x_end ? '0 : x_q + COORD_W'(1);
      y_q <= !vsync ? '0 : !(clken & x_end) ? y_q : y_end ? '0 : y_q + COORD_W'(1);
      if (rise) begin
        top_q <= line_top;
        bottom_q <= line_bottom;
        left_q <= line_left;
        right_q <= line_right;
        v_frac_q <= v_frac;
        h_frac_q <= h_frac;
      end
      for (int k = 0; k < N_H; k++)
        side_q[k] <= rise ? 1'b0 : hit[N_V+k] ? (x_q < pos[0]) : side_q[k];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_cnt <= '0;
      h_cnt <= '0;
      h_side <= '0;
      v_sat <= '0;
      h_sat <= '0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= fall;
      if (fall) begin
        v_cnt <= cnt_all[N_V*CW-1:0];
        h_cnt <= cnt_all[N_L*CW-1:N_V*CW];
        v_sat <= sat_all[N_V-1:0];
        h_sat <= sat_all[N_L-1:N_V];
        h_side <= side_q;
      end
    end
  end
endmodule

// File: tb/tb_scanline_crossing_counter.sv
// tb_scanline_crossing_counter: directed and randomized frames against a sample-sequence reference model
module tb_scanline_crossing_counter;
  localparam int W = 264, H = 210, NV = 2, NH = 3, MG = 3, CW = 4, MAXC = 15, FH = 206;
  localparam int VFW = NV * 4, HFW = NH * 4;
  logic clk = 1'b0, reset = 1'b1, vsync = 1'b0, clken = 1'b0, bin = 1'b0;
  logic [10:0] line_top = '0, line_bottom = '0, line_left = '0, line_right = '0;
  logic [VFW-1:0] v_frac = '0;
  logic [HFW-1:0] h_frac = '0;
  logic [NV*CW-1:0] v_cnt;
  logic [NH*CW-1:0] h_cnt;
  logic [NH-1:0] h_side, h_sat;
  logic [NV-1:0] v_sat;
  logic cnt_valid;
  always #5 clk = ~clk;
  scanline_crossing_counter #(.IMG_W(W), .IMG_H(H), .N_V(NV), .N_H(NH), .MIN_GAP(MG), .CW(CW)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .clken(clken), .bin(bin),
    .line_top(line_top), .line_bottom(line_bottom), .line_left(line_left), .line_right(line_right),
    .v_frac(v_frac), .h_frac(h_frac), .v_cnt(v_cnt), .h_cnt(h_cnt), .h_side(h_side),
    .v_sat(v_sat), .h_sat(h_sat), .cnt_valid(cnt_valid)
  );
  bit img [FH][W];
  int vectors = 0, miscompares = 0;
  int c_top, c_bot, c_left, c_right;
  int c_vf [NV];
  int c_hf [NH];
  int e_vcnt [NV], e_vsat [NV], e_hcnt [NH], e_hsat [NH], e_hside [NH];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int lpos(input int lo, input int hi, input int f);
    return lo + ((hi - lo) * f) / 16;
  endfunction
  task automatic clear_img();
    foreach (img[y, x]) img[y][x] = 1'b0;
  endtask
  task automatic apply_geom();
    line_top = 11'(c_top);
    line_bottom = 11'(c_bot);
    line_left = 11'(c_left);
    line_right = 11'(c_right);
    for (int k = 0; k < NV; k++) v_frac[k*4 +: 4] = 4'(c_vf[k]);
    for (int k = 0; k < NH; k++) h_frac[k*4 +: 4] = 4'(c_hf[k]);
  endtask
  // A 1 counts when at least MG zero samples (frame start counts as a full run) precede it
  task automatic model(input int rows);
    bit ok;
    int n, prev, p, pv0, side;
    ok = (c_right > c_left) && (c_bot > c_top);
    pv0 = lpos(c_left, c_right, c_vf[0]);
    for (int k = 0; k < NV; k++) begin
      n = 0;
      prev = c_top - MG;
      p = lpos(c_left, c_right, c_vf[k]);
      if (ok)
        for (int y = c_top + 1; y < c_bot && y < rows; y++)
          if (img[y][p]) begin
            if (y - prev - 1 >= MG) n++;
            prev = y;
          end
      e_vcnt[k] = n > MAXC ? MAXC : n;
      e_vsat[k] = n > MAXC ? 1 : 0;
    end
    for (int k = 0; k < NH; k++) begin
      n = 0;
      side = 0;
      prev = c_left - MG;
      p = lpos(c_top, c_bot, c_hf[k]);
      if (ok && p < rows)
        for (int x = c_left + 1; x < c_right && x < W; x++)
          if (img[p][x]) begin
            if (x - prev - 1 >= MG) begin
              n++;
              side = x < pv0 ? 1 : 0;
            end
            prev = x;
          end
      e_hcnt[k] = n > MAXC ? MAXC : n;
      e_hsat[k] = n > MAXC ? 1 : 0;
      e_hside[k] = side;
    end
  endtask
  task automatic check_outputs(input string fr);
    for (int k = 0; k < NV; k++) begin
      check($sformatf("%s v_cnt%0d", fr, k), 32'(v_cnt[k*CW +: CW]), e_vcnt[k]);
      check($sformatf("%s v_sat%0d", fr, k), 32'(v_sat[k]), e_vsat[k]);
    end
    for (int k = 0; k < NH; k++) begin
      check($sformatf("%s h_cnt%0d", fr, k), 32'(h_cnt[k*CW +: CW]), e_hcnt[k]);
      check($sformatf("%s h_sat%0d", fr, k), 32'(h_sat[k]), e_hsat[k]);
      check($sformatf("%s h_side%0d", fr, k), 32'(h_side[k]), e_hside[k]);
    end
  endtask
  // Box and fractions are scrambled halfway through every frame; only the captured ones may matter
  task automatic run_frame(input string fr, input int rows, input int gap_pct);
    apply_geom();
    vsync = 1'b0;
    clken = 1'b0;
    step();
    vsync = 1'b1;
    step();
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++) begin
        if (y == rows / 2 && x == 0) begin
          line_top = 11'($urandom);
          line_bottom = 11'($urandom);
          line_left = 11'($urandom);
          line_right = 11'($urandom);
          v_frac = VFW'($urandom);
          h_frac = HFW'($urandom);
        end
        if ($urandom_range(99) < gap_pct) begin
          clken = 1'b0;
          bin = 1'($urandom);
          step();
        end
        clken = 1'b1;
        bin = img[y][x];
        step();
      end
    clken = 1'b0;
    bin = 1'b0;
    check({fr, " cnt_valid_before_fall"}, 32'(cnt_valid), 0);
    vsync = 1'b0;
    step();
    model(rows);
    check({fr, " cnt_valid_pulse"}, 32'(cnt_valid), 1);
    check_outputs(fr);
    step();
    check({fr, " cnt_valid_single"}, 32'(cnt_valid), 0);
  endtask
  initial begin
    reset = 1'b1;
    step();
    step();
    check("reset v_cnt", 32'(v_cnt), 0);
    check("reset h_cnt", 32'(h_cnt), 0);
    check("reset flags", 32'({h_side, v_sat, h_sat}), 0);
    check("reset cnt_valid", 32'(cnt_valid), 0);
    reset = 1'b0;
    // blank frame
    clear_img();
    c_top = 10; c_bot = 100; c_left = 20; c_right = 200;
    c_vf = '{8, 4}; c_hf = '{8, 4, 12};
    run_frame("blank", 2, 0);
    check("blank all_zero", 32'({v_cnt, h_cnt, v_sat, h_sat}), 0);
    // gap rule and saturation along horizontal lines at y=5, 7, 8
    clear_img();
    c_top = 1; c_bot = 9; c_left = 2; c_right = 250;
    c_vf = '{4, 12}; c_hf = '{8, 12, 15};
    img[5][10] = 1'b1; img[5][13] = 1'b1;
    img[7][10] = 1'b1; img[7][14] = 1'b1;
    for (int i = 0; i < 20; i++) img[8][20 + 4 * i] = 1'b1;
    run_frame("gap", 9, 0);
    check("gap 1001", 32'(h_cnt[3:0]), 1);
    check("gap 10001", 32'(h_cnt[7:4]), 2);
    check("sat count", 32'(h_cnt[11:8]), 15);
    check("sat flag", 32'(h_sat[2]), 1);
    // figure box with two full bars and a single mark left of vertical line 0
    clear_img();
    c_top = 50; c_bot = 250; c_left = 100; c_right = 260;
    c_vf = '{8, 4}; c_hf = '{8, 4, 12};
    for (int x = 0; x < W; x++)
      for (int y = 0; y < 5; y++) begin
        img[80 + y][x] = 1'b1;
        img[200 + y][x] = 1'b1;
      end
    img[150][120] = 1'b1;
    run_frame("box", 205, 0);
    check("box v_cnt0", 32'(v_cnt[3:0]), 2);
    check("box h_side0", 32'(h_side[0]), 1);
    // reset in the middle of a frame: outputs clear and the cut frame is never published
    apply_geom();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      clken = 1'b1;
      bin = 1'($urandom);
      step();
    end
    reset = 1'b1;
    clken = 1'b0;
    step();
    check("midreset v_cnt", 32'(v_cnt), 0);
    check("midreset h_cnt", 32'(h_cnt), 0);
    check("midreset flags", 32'({h_side, v_sat, h_sat}), 0);
    check("midreset cnt_valid", 32'(cnt_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      clken = 1'b1;
      bin = 1'b1;
      step();
    end
    clken = 1'b0;
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("truncated no_pulse%0d", i), 32'(cnt_valid), 0);
    end
    check("truncated v_cnt", 32'(v_cnt), 0);
    // randomized frames, some with degenerate boxes
    for (int f = 0; f < 4; f++) begin
      clear_img();
      c_left = $urandom_range(0, 150);
      c_top = $urandom_range(0, 5);
      if (f % 3 == 2) begin
        c_right = $urandom_range(0, 263);
        c_bot = $urandom_range(0, 13);
      end else begin
        c_right = c_left + $urandom_range(20, 110);
        c_bot = c_top + $urandom_range(3, 8);
      end
      for (int k = 0; k < NV; k++) c_vf[k] = $urandom_range(0, 15);
      for (int k = 0; k < NH; k++) c_hf[k] = $urandom_range(0, 15);
      for (int y = 0; y < 14; y++)
        for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(99) < 25);
      run_frame($sformatf("rand%0d", f), 14, 20);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
